rom_bus_bridge: RTL and testbench

- Upstream feeder for the SPI flash ROM reader: sits between the 68040 processor bus and the ROM's access_stb/access_ack/access_addr/access_odata interface.
- Decodes processor transfer starts aimed at the ROM window.
- Turns each read, including 4-beat line bursts, into one or four single-longword ROM accesses and returns the data with TA.
- Writes and hung accesses terminate with TEA.

---
 rtl/rom_bridge_pkg.sv | 21 ++
 rtl/bus_timeout_counter.sv | 34 +++
 rtl/rom_bus_bridge.sv | 152 +++++++++++++++
 tb/tb_rom_bus_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_bridge_pkg.sv
// Shared types and constants for the 68040-to-ROM bus bridge.
package rom_bridge_pkg;

  // Longword address width seen by the ROM reader (cpu_addr[23:2]).
  localparam int ROM_ADDR_W = 22;

  // 68040 SIZ encodings.
  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Per-beat watchdog: counts cycles since the ROM request was issued and
// flags the cycle in which the count steps onto TIMEOUT-1.
module bus_timeout_counter #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over count so a new beat always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Asserted while the increment lands on TIMEOUT-1, so the error
  // handshake that follows completes TIMEOUT cycles after the strobe.
  assign expired = en && !clr && (cnt_q == CW'(TIMEOUT - 2));

endmodule

// File: rtl/rom_bus_bridge.sv
// 68040 bus slave for the SPI flash ROM window. Each read (line bursts
// split into four wrapping longword beats) becomes single ROM accesses
// answered with TA; writes and timed-out beats answer with TEA.
module rom_bus_bridge
  import rom_bridge_pkg::*;
#(
  parameter logic [7:0] ROM_BASE = 8'hFF,
  parameter int         TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_ts_n,
  input  logic [31:0]           cpu_addr,
  input  logic                  cpu_rw,
  input  logic [1:0]            cpu_siz,
  output logic                  cpu_ta_n,
  output logic                  cpu_tea_n,
  output logic [31:0]           cpu_data,
  output logic                  cpu_data_oe,
  output logic                  access_stb,
  output logic [ROM_ADDR_W-1:0] access_addr,
  input  logic [31:0]           access_odata,
  input  logic                  access_ack
);

  state_e                  state_q, state_d;
  logic [1:0]              beats_q, beats_d;   // beats still to fetch after the current one
  logic                    line_q, line_d;
  logic [ROM_ADDR_W-1:0]   addr_q, addr_d;
  logic                    stb_q, stb_d;
  logic                    ta_n_q, ta_n_d;
  logic                    tea_n_q, tea_n_d;
  logic [31:0]             data_q, data_d;
  logic                    oe_q, oe_d;
  logic                    tmr_clr, tmr_en, tmr_exp;
  logic                    sel;

  // Byte lanes are picked by the processor; the low address bits are don't-care.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cpu_addr[1:0];

  assign sel = !cpu_ts_n && (cpu_addr[31:24] == ROM_BASE);

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  // Transfer sequencer: every output is computed here as the value for the
  // state being entered, so all bus signals leave the block from flops.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    line_d  = line_q;
    addr_d  = addr_q;
    stb_d   = 1'b0;
    ta_n_d  = 1'b1;
    tea_n_d = 1'b1;
    data_d  = data_q;
    oe_d    = oe_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel) begin
          if (cpu_rw) begin
            addr_d  = cpu_addr[23:2];
            line_d  = (cpu_siz == SIZ_LINE);
            beats_d = (cpu_siz == SIZ_LINE) ? 2'd3 : 2'd0;
            stb_d   = 1'b1;
            tmr_clr = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_REQ: begin
        tmr_en  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        if (access_ack) begin
          data_d  = access_odata;
          oe_d    = 1'b1;
          ta_n_d  = 1'b0;
          state_d = ST_DONE;
        end else if (tmr_exp) begin
          oe_d    = 1'b0;
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        if (line_q && (beats_q != 2'd0)) begin
          // Line bursts wrap inside the 16-byte line.
          beats_d     = beats_q - 2'd1;
          addr_d[1:0] = addr_q[1:0] + 2'd1;
          stb_d       = 1'b1;
          tmr_clr     = 1'b1;
          state_d     = ST_REQ;
        end else begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        tea_n_d = 1'b0;
        oe_d    = 1'b0;
        beats_d = 2'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beats_q <= 2'd0;
      line_q  <= 1'b0;
      addr_q  <= '0;
      stb_q   <= 1'b0;
      ta_n_q  <= 1'b1;
      tea_n_q <= 1'b1;
      data_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      stb_q   <= stb_d;
      ta_n_q  <= ta_n_d;
      tea_n_q <= tea_n_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
    end
  end

  assign cpu_ta_n    = ta_n_q;
  assign cpu_tea_n   = tea_n_q;
  assign cpu_data    = data_q;
  assign cpu_data_oe = oe_q;
  assign access_stb  = stb_q;
  assign access_addr = addr_q;

endmodule

// File: tb/tb_rom_bus_bridge.sv
// Directed + randomized bench for rom_bus_bridge with an event-level model.
module tb_rom_bus_bridge;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ts_n = 1'b1;
  logic [31:0] cpu_addr = 32'h0;
  logic        cpu_rw = 1'b1;
  logic [1:0]  cpu_siz = 2'b00;
  logic        cpu_ta_n, cpu_tea_n, cpu_data_oe, access_stb;
  logic [31:0] cpu_data;
  logic [21:0] access_addr;
  logic [31:0] access_odata;
  logic        access_ack;

  rom_bus_bridge #(.ROM_BASE(8'hFF), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_ts_n     (cpu_ts_n),
    .cpu_addr     (cpu_addr),
    .cpu_rw       (cpu_rw),
    .cpu_siz      (cpu_siz),
    .cpu_ta_n     (cpu_ta_n),
    .cpu_tea_n    (cpu_tea_n),
    .cpu_data     (cpu_data),
    .cpu_data_oe  (cpu_data_oe),
    .access_stb   (access_stb),
    .access_addr  (access_addr),
    .access_odata (access_odata),
    .access_ack   (access_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Bus event log, sampled mid-cycle.
  int          stb_cyc[$];
  logic [21:0] stb_addr[$];
  int          ta_cyc[$];
  logic [31:0] ta_data[$];
  int          tea_cyc[$];
  int          overlap = 0;
  int          oe_bad = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (access_stb) begin
        stb_cyc.push_back(cyc);
        stb_addr.push_back(access_addr);
      end
      if (!cpu_ta_n) begin
        ta_cyc.push_back(cyc);
        ta_data.push_back(cpu_data);
        if (!cpu_data_oe) oe_bad++;
      end
      if (!cpu_tea_n) tea_cyc.push_back(cyc);
      if (!cpu_ta_n && !cpu_tea_n) overlap++;
    end
  end

  // ROM responder: acks ack_dly cycles after each strobe (0 = never acks).
  int          ack_dly = 1;
  logic [31:0] rom_q[$];
  initial begin
    access_ack   = 1'b0;
    access_odata = 32'h0;
    forever begin
      @(negedge clk);
      access_ack = 1'b0;
      if (access_stb && ack_dly > 0) begin
        repeat (ack_dly) @(negedge clk);
        access_odata = (rom_q.size() > 0) ? rom_q.pop_front() : $urandom;
        access_ack   = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    stb_cyc.delete(); stb_addr.delete();
    ta_cyc.delete();  ta_data.delete();
    tea_cyc.delete();
  endtask

  // Issue one transfer and compare the bus events with what the bridge rules predict.
  task automatic run_xfer(input string tag, input logic [31:0] a, input logic rw,
                          input logic [1:0] siz, input int dly);
    int ts, nb, n_stb, n_ta, n_tea, tea_at, stb_at;
    logic hit;
    logic [21:0] base, exp_addr;
    logic [31:0] words[$];
    logic [31:0] w;
    hit  = (a[31:24] == 8'hFF);
    base = a[23:2];
    nb   = (siz == 2'b11) ? 4 : 1;
    clear_log();
    rom_q.delete();
    ack_dly = dly;
    for (int i = 0; i < nb; i++) begin
      w = $urandom;
      words.push_back(w);
      rom_q.push_back(w);
    end
    @(negedge clk);
    cpu_ts_n = 1'b0; cpu_addr = a; cpu_rw = rw; cpu_siz = siz;
    ts = cyc;
    @(negedge clk);
    cpu_ts_n = 1'b1; cpu_addr = $urandom; cpu_rw = $urandom_range(0, 1);
    repeat (nb * (dly + 2) + TIMEOUT + 6) @(negedge clk);

    // Expected event counts from the transfer type.
    n_stb = 0; n_ta = 0; n_tea = 0; tea_at = 0;
    if (hit && !rw) begin
      n_tea = 1; tea_at = ts + 2;
    end else if (hit && dly == 0) begin
      n_stb = 1; n_tea = 1; tea_at = ts + 1 + TIMEOUT;
    end else if (hit) begin
      n_stb = nb; n_ta = nb;
    end
    chk({tag, ".stb_count"}, stb_cyc.size(), n_stb);
    chk({tag, ".ta_count"},  ta_cyc.size(),  n_ta);
    chk({tag, ".tea_count"}, tea_cyc.size(), n_tea);
    for (int k = 0; k < n_stb && k < stb_cyc.size(); k++) begin
      stb_at   = ts + 1 + k * (dly + 2);
      exp_addr = (base & ~22'd3) | ((base + 22'(k)) & 22'd3);
      chk($sformatf("%s.stb%0d_cycle", tag, k), stb_cyc[k], stb_at);
      chk($sformatf("%s.stb%0d_addr", tag, k), 32'(stb_addr[k]), 32'(exp_addr));
    end
    for (int k = 0; k < n_ta && k < ta_cyc.size(); k++) begin
      chk($sformatf("%s.ta%0d_cycle", tag, k), ta_cyc[k], ts + 1 + k * (dly + 2) + dly + 1);
      chk($sformatf("%s.ta%0d_data", tag, k), ta_data[k], words[k]);
    end
    if (n_tea > 0 && tea_cyc.size() > 0)
      chk({tag, ".tea_cycle"}, tea_cyc[0], tea_at);
    chk({tag, ".idle_oe"}, 32'(cpu_data_oe), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  rs;
    int          n;

    #1 rst = 1'b1;
    #1;
    chk("reset.ta_n",  32'(cpu_ta_n),    32'd1);
    chk("reset.tea_n", 32'(cpu_tea_n),   32'd1);
    chk("reset.oe",    32'(cpu_data_oe), 32'd0);
    chk("reset.data",  cpu_data,         32'd0);
    chk("reset.stb",   32'(access_stb),  32'd0);
    chk("reset.addr",  32'(access_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer("long_read",   32'hFF000010, 1'b1, 2'b00, 5);
    run_xfer("line_read",   32'hFF00002C, 1'b1, 2'b11, 3);
    run_xfer("write",       32'hFF000000, 1'b0, 2'b00, 2);
    run_xfer("outside",     32'h00001000, 1'b1, 2'b00, 2);
    run_xfer("timeout",     32'hFF000400, 1'b1, 2'b00, 0);
    run_xfer("after_to",    32'hFF000404, 1'b1, 2'b10, 1);

    for (int i = 0; i < 8; i++) begin
      r  = $urandom;
      rs = 2'($urandom_range(0, 3));
      r[31:24] = (i == 5) ? 8'h7E : 8'hFF;
      run_xfer($sformatf("rand%0d", i), r, (i != 6), rs, $urandom_range(1, 6));
    end

    // Reset in the middle of a line burst, then a late ack from the ROM.
    clear_log();
    rom_q.delete();
    ack_dly = 6;
    for (int i = 0; i < 4; i++) rom_q.push_back($urandom);
    @(negedge clk);
    cpu_ts_n = 1'b0; cpu_addr = 32'hFF000100; cpu_rw = 1'b1; cpu_siz = 2'b11;
    @(negedge clk);
    cpu_ts_n = 1'b1;
    n = 0;
    while (stb_cyc.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid.reached_beat1", stb_cyc.size(), 2);
    chk("rst_mid.ta_before", ta_cyc.size(), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.ta_n",  32'(cpu_ta_n),    32'd1);
    chk("rst_mid.tea_n", 32'(cpu_tea_n),   32'd1);
    chk("rst_mid.oe",    32'(cpu_data_oe), 32'd0);
    chk("rst_mid.data",  cpu_data,         32'd0);
    chk("rst_mid.stb",   32'(access_stb),  32'd0);
    chk("rst_mid.addr",  32'(access_addr), 32'd0);
    clear_log();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("late_ack.no_ta",  ta_cyc.size(),  0);
    chk("late_ack.no_tea", tea_cyc.size(), 0);
    chk("late_ack.no_stb", stb_cyc.size(), 0);
    run_xfer("after_rst", 32'hFF000020, 1'b1, 2'b00, 2);

    chk("ta_tea_overlap", overlap, 0);
    chk("ta_without_oe",  oe_bad,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
